// File: rtl/codec_init_sequencer.sv
// codec_init_sequencer: streams a parameter-sized {reg,data} table to one
// I2C device with bounded retries, settle delay, restart and status.
module codec_init_sequencer #(
  parameter int         N_CMDS        = 10,
  parameter logic [6:0] DEV_ADDR      = 7'h1A,
  parameter int         MAX_RETRIES   = 3,
  parameter int         SETTLE_CYCLES = 4,
  parameter bit         AUTO_START    = 1'b1
) (
  input  logic                  i2c_clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [16*N_CMDS-1:0]  cmd_table,
  output logic [6:0]            slav_addr,
  output logic                  read_not_write,
  output logic [7:0]            reg_addr,
  output logic [7:0]            write_data,
  output logic                  write_valid,
  input  logic                  write_ready,
  input  logic                  error,
  output logic                  busy,
  output logic                  done,
  output logic                  fail,
  output logic [7:0]            cmd_index,
  output logic [3:0]            retry_cnt
);

  if (N_CMDS < 1 || N_CMDS > 255) begin : g_bad_ncmds
    $error("codec_init_sequencer: N_CMDS must be in 1..255");
  end
  if (MAX_RETRIES < 0 || MAX_RETRIES > 15) begin : g_bad_retries
    $error("codec_init_sequencer: MAX_RETRIES must be in 0..15");
  end
  if (SETTLE_CYCLES < 0 || SETTLE_CYCLES > 65535) begin : g_bad_settle
    $error("codec_init_sequencer: SETTLE_CYCLES must be in 0..65535");
  end

  localparam int         SL_INT   = (SETTLE_CYCLES > 0) ? SETTLE_CYCLES - 1 : 0;
  localparam logic [15:0] SL      = 16'(SL_INT);
  localparam logic [7:0]  LAST    = 8'(N_CMDS - 1);
  localparam logic [3:0]  RMAX    = 4'(MAX_RETRIES);
  localparam bit          NO_WAIT = (SETTLE_CYCLES == 0);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_XFER,
    S_SETTLE,
    S_DONE,
    S_FAIL
  } state_t;

  state_t      state_q, state_d;
  logic [7:0]  idx_q, idx_d;
  logic [3:0]  rc_q, rc_d;
  logic [7:0]  ra_q, ra_d;
  logic [7:0]  wd_q, wd_d;
  logic [15:0] sc_q, sc_d;
  logic [15:0] cmd_word;
  logic        xfer_ok;

  assign cmd_word = cmd_table[{idx_q, 4'b0000} +: 16];

  // An X on error must never be mistaken for a clean acknowledge.
  assign xfer_ok = write_ready && (error === 1'b0);

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    rc_d    = rc_q;
    ra_d    = ra_q;
    wd_d    = wd_q;
    sc_d    = sc_q;
    unique case (state_q)
      S_IDLE: begin
        if (AUTO_START || start) begin
          idx_d   = 8'd0;
          rc_d    = 4'd0;
          state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        ra_d    = cmd_word[15:8];
        wd_d    = cmd_word[7:0];
        state_d = S_XFER;
      end
      S_XFER: begin
        if (write_ready) begin
          if (xfer_ok) begin
            rc_d    = 4'd0;
            sc_d    = 16'd0;
            state_d = S_SETTLE;
          end else if (rc_q < RMAX) begin
            rc_d    = rc_q + 4'd1;
            state_d = S_LOAD;
          end else begin
            state_d = S_FAIL;
          end
        end
      end
      S_SETTLE: begin
        if (NO_WAIT || sc_q == SL) begin
          if (idx_q == LAST) begin
            state_d = S_DONE;
          end else begin
            idx_d   = idx_q + 8'd1;
            state_d = S_LOAD;
          end
        end else begin
          sc_d = sc_q + 16'd1;
        end
      end
      S_DONE, S_FAIL: begin
        if (start) begin
          idx_d   = 8'd0;
          rc_d    = 4'd0;
          state_d = S_LOAD;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge i2c_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      idx_q   <= 8'd0;
      rc_q    <= 4'd0;
      ra_q    <= 8'd0;
      wd_q    <= 8'd0;
      sc_q    <= 16'd0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      rc_q    <= rc_d;
      ra_q    <= ra_d;
      wd_q    <= wd_d;
      sc_q    <= sc_d;
    end
  end

  assign slav_addr      = DEV_ADDR;
  assign read_not_write = 1'b0;
  assign reg_addr       = ra_q;
  assign write_data     = wd_q;
  assign cmd_index      = idx_q;
  assign retry_cnt      = rc_q;
  assign write_valid    = (state_q == S_XFER);
  assign busy           = (state_q == S_LOAD) ||
                          (state_q == S_XFER) ||
                          (state_q == S_SETTLE);
  assign done           = (state_q == S_DONE);
  assign fail           = (state_q == S_FAIL);

endmodule

// File: tb/tb_codec_init_sequencer.sv
// Scoreboard bench: two sequencers (auto-start and manual-start) driven by
// a behavioural i2c_master responder with programmable NACK injection.
`timescale 1ns/1ps
module tb_codec_init_sequencer;

  localparam int N = 10;

  typedef struct {
    int idx;
    int rc;
    bit err;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst_n;
  logic [16*N-1:0] tbl;

  logic       start_a, ready_a, err_a, rnw_a, valid_a;
  logic       busy_a, done_a, fail_a;
  logic [6:0] slav_a;
  logic [7:0] ra_a, wd_a, idx_a;
  logic [3:0] rc_a;

  logic       start_b, ready_b, err_b, rnw_b, valid_b;
  logic       busy_b, done_b, fail_b;
  logic [6:0] slav_b;
  logic [7:0] ra_b, wd_b, idx_b;
  logic [3:0] rc_b;

  int   n_vec, n_err;
  exp_t qa[$];
  exp_t qb[$];
  int   nack_idx, nack_left;

  codec_init_sequencer #(
    .N_CMDS(N), .DEV_ADDR(7'h1A), .MAX_RETRIES(3),
    .SETTLE_CYCLES(4), .AUTO_START(1'b1)
  ) u_a (
    .i2c_clk(clk), .rst_n(rst_n), .start(start_a), .cmd_table(tbl),
    .slav_addr(slav_a), .read_not_write(rnw_a), .reg_addr(ra_a),
    .write_data(wd_a), .write_valid(valid_a), .write_ready(ready_a),
    .error(err_a), .busy(busy_a), .done(done_a), .fail(fail_a),
    .cmd_index(idx_a), .retry_cnt(rc_a)
  );

  codec_init_sequencer #(
    .N_CMDS(N), .DEV_ADDR(7'h1A), .MAX_RETRIES(3),
    .SETTLE_CYCLES(4), .AUTO_START(1'b0)
  ) u_b (
    .i2c_clk(clk), .rst_n(rst_n), .start(start_b), .cmd_table(tbl),
    .slav_addr(slav_b), .read_not_write(rnw_b), .reg_addr(ra_b),
    .write_data(wd_b), .write_valid(valid_b), .write_ready(ready_b),
    .error(err_b), .busy(busy_b), .done(done_b), .fail(fail_b),
    .cmd_index(idx_b), .retry_cnt(rc_b)
  );

  function automatic logic [8:0] cmd_data(input int k);
    logic [8:0] d;
    d = 9'(9'h039 + k);
    if (k % 2 == 1) d = d + 9'h100;
    return d;
  endfunction

  function automatic logic [7:0] exp_ra(input int k);
    logic [8:0] d;
    d = cmd_data(k);
    return {7'(k), d[8]};
  endfunction

  function automatic logic [7:0] exp_wd(input int k);
    logic [8:0] d;
    d = cmd_data(k);
    return d[7:0];
  endfunction

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic push_a(input int k, input int rc, input bit err);
    exp_t e;
    e.idx = k; e.rc = rc; e.err = err;
    qa.push_back(e);
  endtask

  task automatic push_b(input int k);
    exp_t e;
    e.idx = k; e.rc = 0; e.err = 1'b0;
    qb.push_back(e);
  endtask

  // i2c_master model: ends each transfer on the second XFER cycle
  int cnt_a;
  initial begin
    ready_a = 1'b0; err_a = 1'b0; cnt_a = 0;
    forever begin
      @(negedge clk);
      ready_a = 1'b0; err_a = 1'b0;
      if (rst_n && valid_a) begin
        cnt_a++;
        if (cnt_a == 2) begin
          cnt_a   = 0;
          ready_a = 1'b1;
          if (int'(idx_a) == nack_idx && nack_left != 0) begin
            err_a = 1'b1;
            if (nack_left > 0) nack_left--;
          end
        end
      end else begin
        cnt_a = 0;
      end
    end
  end

  int cnt_b;
  initial begin
    ready_b = 1'b0; err_b = 1'b0; cnt_b = 0;
    forever begin
      @(negedge clk);
      ready_b = 1'b0; err_b = 1'b0;
      if (rst_n && valid_b) begin
        cnt_b++;
        if (cnt_b == 2) begin
          cnt_b   = 0;
          ready_b = 1'b1;
        end
      end else begin
        cnt_b = 0;
      end
    end
  end

  // Monitor A: transfer fields plus the idle gap before the next request
  int gap_a, gap_exp_a;
  bit gap_on_a;
  initial begin
    exp_t e;
    gap_on_a = 1'b0; gap_a = 0; gap_exp_a = 0;
    forever begin
      @(negedge clk); #1;
      if (!rst_n) begin
        gap_on_a = 1'b0;
      end else begin
        if (gap_on_a) begin
          if (valid_a) begin
            chk("gap_a", 32'(gap_a), 32'(gap_exp_a));
            gap_on_a = 1'b0;
          end else begin
            gap_a++;
          end
        end
        if (ready_a) begin
          if (qa.size() == 0) begin
            n_vec++; n_err++;
            $display("FAIL xfer_a_unexpected: idx %0d reg %h data %h",
                     idx_a, ra_a, wd_a);
          end else begin
            e = qa.pop_front();
            chk($sformatf("xfer_a_%0d", e.idx),
                32'({slav_a, rnw_a, ra_a, wd_a, rc_a}),
                32'({7'h1A, 1'b0, exp_ra(e.idx), exp_wd(e.idx), 4'(e.rc)}));
            if (e.idx == 4)
              chk("cmd4_fields", 32'({slav_a, ra_a, wd_a}),
                  32'({7'h1A, 8'h08, 8'h3D}));
            if (!e.err && e.idx != N - 1) begin
              gap_on_a = 1'b1; gap_a = 0; gap_exp_a = 5;
            end else if (e.err && e.rc < 3) begin
              gap_on_a = 1'b1; gap_a = 0; gap_exp_a = 1;
            end
          end
        end
      end
    end
  end

  initial begin
    exp_t e;
    forever begin
      @(negedge clk); #1;
      if (rst_n && ready_b) begin
        if (qb.size() == 0) begin
          n_vec++; n_err++;
          $display("FAIL xfer_b_unexpected: idx %0d reg %h data %h",
                   idx_b, ra_b, wd_b);
        end else begin
          e = qb.pop_front();
          chk($sformatf("xfer_b_%0d", e.idx),
              32'({slav_b, rnw_b, ra_b, wd_b, rc_b}),
              32'({7'h1A, 1'b0, exp_ra(e.idx), exp_wd(e.idx), 4'd0}));
        end
      end
    end
  end

  task automatic pulse_a();
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
  endtask

  task automatic pulse_b();
    start_b = 1'b1;
    @(negedge clk);
    start_b = 1'b0;
  endtask

  initial begin
    n_vec = 0; n_err = 0;
    nack_idx = -1; nack_left = 0;
    rst_n = 1'b0; start_a = 1'b0; start_b = 1'b0;
    for (int k = 0; k < N; k++) tbl[16*k +: 16] = {7'(k), cmd_data(k)};
    repeat (3) @(negedge clk);
    chk("reset_a", {valid_a, busy_a, done_a, fail_a, idx_a, rc_a, ra_a, wd_a},
        32'd0);
    chk("reset_b", {valid_b, busy_b, done_b, fail_b, idx_b, rc_b, ra_b, wd_b},
        32'd0);

    // all acked, auto start
    for (int k = 0; k < N; k++) push_a(k, 0, 1'b0);
    rst_n = 1'b1;
    for (int i = 0; i < 1000 && !done_a; i++) @(negedge clk);
    chk("t1_done", 32'(done_a), 32'd1);
    chk("t1_idx", 32'(idx_a), 32'd9);
    chk("t1_busy_fail", {30'd0, busy_a, fail_a}, 32'd0);
    chk("t1_q_empty", 32'(qa.size()), 32'd0);
    chk("b_idle_no_start", {29'd0, valid_b, busy_b, done_b}, 32'd0);

    // manual start, start during XFER ignored, replay after done
    for (int k = 0; k < N; k++) push_b(k);
    pulse_b();
    for (int i = 0; i < 1000 && !(valid_b && idx_b == 8'd3); i++)
      @(negedge clk);
    chk("t5_xfer3", 32'({valid_b, idx_b}), 32'({1'b1, 8'd3}));
    pulse_b();
    for (int i = 0; i < 1000 && !done_b; i++) @(negedge clk);
    chk("t5_done1", 32'({done_b, idx_b}), 32'({1'b1, 8'd9}));
    chk("t5_q1_empty", 32'(qb.size()), 32'd0);
    for (int k = 0; k < N; k++) push_b(k);
    pulse_b();
    chk("t5_restart", 32'({busy_b, done_b}), 32'({1'b1, 1'b0}));
    for (int i = 0; i < 1000 && !done_b; i++) @(negedge clk);
    chk("t5_done2", 32'({done_b, idx_b}), 32'({1'b1, 8'd9}));
    chk("t5_q2_empty", 32'(qb.size()), 32'd0);

    // command 2 NACKed twice then acked
    nack_idx = 2; nack_left = 2;
    for (int k = 0; k < N; k++) begin
      if (k == 2) begin
        push_a(2, 0, 1'b1);
        push_a(2, 1, 1'b1);
        push_a(2, 2, 1'b0);
      end else begin
        push_a(k, 0, 1'b0);
      end
    end
    pulse_a();
    for (int i = 0; i < 1000 && !done_a; i++) @(negedge clk);
    chk("t2_status", 32'({done_a, fail_a, rc_a, idx_a}),
        32'({1'b1, 1'b0, 4'd0, 8'd9}));
    chk("t2_q_empty", 32'(qa.size()), 32'd0);

    // command 5 always NACKed
    nack_idx = 5; nack_left = -1;
    for (int k = 0; k < 5; k++) push_a(k, 0, 1'b0);
    for (int r = 0; r < 4; r++) push_a(5, r, 1'b1);
    pulse_a();
    for (int i = 0; i < 1000 && !fail_a; i++) @(negedge clk);
    chk("t3_fail", 32'({fail_a, done_a, busy_a, valid_a}),
        32'({1'b1, 1'b0, 1'b0, 1'b0}));
    chk("t3_idx_rc", 32'({idx_a, rc_a}), 32'({8'd5, 4'd3}));
    repeat (20) @(negedge clk);
    chk("t3_hold", 32'({fail_a, valid_a, idx_a}), 32'({1'b1, 1'b0, 8'd5}));
    chk("t3_q_empty", 32'(qa.size()), 32'd0);

    // reset in the middle of command 3
    nack_idx = -1; nack_left = 0;
    for (int k = 0; k < 3; k++) push_a(k, 0, 1'b0);
    pulse_a();
    chk("t6_fail_cleared", 32'(fail_a), 32'd0);
    for (int i = 0; i < 1000 && !(valid_a && idx_a == 8'd3); i++)
      @(negedge clk);
    chk("t6_in_xfer3", 32'({valid_a, idx_a}), 32'({1'b1, 8'd3}));
    #2 rst_n = 1'b0;
    #1 chk("t6_async", 32'({valid_a, busy_a, idx_a}), 32'd0);
    chk("t6_q_empty", 32'(qa.size()), 32'd0);
    @(negedge clk);
    @(negedge clk);
    for (int k = 0; k < N; k++) push_a(k, 0, 1'b0);
    rst_n = 1'b1;
    for (int i = 0; i < 1000 && !done_a; i++) @(negedge clk);
    chk("t6_done", 32'({done_a, idx_a}), 32'({1'b1, 8'd9}));
    chk("t6_q_empty2", 32'(qa.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/codec_init_sequencer.md
Name: codec_init_sequencer

Overview:
Parametrised I2C register-initialisation sequencer and the successor to the fixed 10-command audio-codec init FSM. It sits between the system and i2c_master. It takes its command list as a flattened parameter-sized table of {7-bit reg, 9-bit data} words and streams them to one device address. Over the fixed version it adds bounded retries, an inter-command settle delay, a restart input, and busy/done/fail status.

Parameters:
N_CMDS, 10, number of command words in cmd_table (1..255)
DEV_ADDR, 7'h1A, 7-bit I2C slave address for every write
MAX_RETRIES, 3, retries per command after an errored transfer (0 = no retry)
SETTLE_CYCLES, 4, idle i2c_clk cycles inserted after each successful write (0 = none)
AUTO_START, 1, 1 = begin sequence on reset release; 0 = wait for start

Ports:
i2c_clk  in  1  sequencer and I2C master clock
rst_n  in  1  asynchronous active-low reset
start  in  1  pulse; (re)starts sequence from index 0 when in IDLE, DONE or FAIL; ignored while busy
cmd_table  in  16*N_CMDS  command k at bits [16k+15:16k] = {reg[6:0], data[8:0]}; must be static while busy
slav_addr  out  7  to i2c_master; always DEV_ADDR
read_not_write  out  1  to i2c_master; constant 0
reg_addr  out  8  {reg[6:0], data[8]} of the current command
write_data  out  8  data[7:0] of the current command
write_valid  out  1  request to i2c_master; high only in state XFER
write_ready  in  1  one-cycle pulse from i2c_master when the transfer ends
error  in  1  NACK/bus error; qualified by write_ready
busy  out  1  high in LOAD, XFER and SETTLE
done  out  1  level; high in DONE
fail  out  1  level; high in FAIL
cmd_index  out  8  index of the current or last command
retry_cnt  out  4  retries consumed on the current command

Behaviour:
- Reset (async assert, synchronous deassert handled upstream) forces: state IDLE; write_valid=0; busy=0; done=0; fail=0; cmd_index=0; retry_cnt=0; reg_addr=0; write_data=0.
- An asserted rst_n mid-transfer drops write_valid immediately. There is no bus recovery; i2c_master owns that.
- States and transitions:
  - IDLE: go to LOAD if AUTO_START=1 (first cycle after reset) or if start=1.
  - LOAD: register reg_addr/write_data from cmd_table[cmd_index]. Next state XFER. Outputs are stable for the whole of XFER.
  - XFER: write_valid=1.
    - write_ready=1 and error=0: retry_cnt<=0, go to SETTLE.
    - write_ready=1 and error=1: if retry_cnt<MAX_RETRIES, retry_cnt++ and go to LOAD (same index). Otherwise go to FAIL.
    - write_ready=0: stay.
  - SETTLE: count SETTLE_CYCLES cycles (0 means a single pass-through cycle). Then:
    - if cmd_index==N_CMDS-1, go to DONE;
    - else cmd_index++ and go to LOAD.
  - DONE: done=1. On start, clear done, set cmd_index=0 and retry_cnt=0, go to LOAD.
  - FAIL: fail=1; cmd_index and retry_cnt hold the failing command's values. On start, clear fail, reset the index, go to LOAD.
- Latency per successful command: 1 (LOAD) + transfer time + max(SETTLE_CYCLES,1).
- Every command is sent exactly once per success, including index 0. There is no skipped entry.
- error is ignored when write_ready=0. Unknown/X on error is treated as an error.
- start during LOAD/XFER/SETTLE is ignored. start in IDLE with AUTO_START=1 coincident with the auto-start cycle produces one sequence, not two.
- cmd_index is 8 bits wide; N_CMDS>255 is illegal and triggers an elaboration-time assertion.
- The retry counter saturates at MAX_RETRIES and never wraps.

Test Plan:
1. N_CMDS=10, DEV_ADDR=7'h1A, model acks every write. Expect:
   - 10 transfers in order; command 4 {7'h04, 9'h03D} shows reg_addr=8'h08, write_data=8'h3D, slav_addr=7'h1A;
   - done=1 and cmd_index=9 at end; busy=0.
2. Model NACKs command 2 twice then acks, MAX_RETRIES=3. Expect:
   - command 2 sent 3 times with identical fields; retry_cnt reaches 2 then clears;
   - sequence completes with done=1, fail=0.
3. Model NACKs command 5 always, MAX_RETRIES=3. Expect 4 attempts, then fail=1, cmd_index=5, retry_cnt=3, write_valid=0, and no command 6 issued.
4. SETTLE_CYCLES=4. Expect exactly 4 cycles with write_valid=0 between each write_ready and the next write_valid rise (5 including LOAD).
5. AUTO_START=0: no activity until a start pulse. After done, a second start replays all commands from index 0. A start pulse during XFER has no effect.
6. Deassert rst_n in the middle of command 3's XFER. Expect write_valid, busy and cmd_index to be 0 immediately. After release with AUTO_START=1, the sequence restarts at command 0.
